// File: rtl/debug_bram_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : debug_bram_sequencer
// Purpose  : Host-driven sequencer for the RV32ICore debug BRAM ports. It
//            loads InstCache/DataCache through port 2, releases the core from
//            reset for a bounded number of cycles, and dumps either BRAM back
//            out as a word stream. It owns the core reset.
// Ports    : CPU_CLK / CPU_RST         clock, asynchronous active-high reset
//            cmd_valid/ready/op/target/arg   command channel
//            wr_valid/ready/data       load word stream into the block
//            rd_valid/ready/data/last  dump word stream out of the block
//            core_rst                  RV32ICore reset, low only while running
//            busy / done               status; done is a one-cycle pulse
//            CPU_Debug_DataCache_*2    DataCache port 2 (A2/WD2/WE2/RD2)
//            CPU_Debug_InstCache_*2    InstCache port 2 (A2/WD2/WE2/RD2)
// Revision : 1.0  initial release
// ============================================================================
module debug_bram_sequencer #(
   parameter int BRAMWORDS = 4096,
   parameter int CNT_W     = 13
) (
   input  logic        CPU_CLK,
   input  logic        CPU_RST,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic        cmd_target,
   input  logic [31:0] cmd_arg,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [31:0] rd_data,
   output logic        rd_last,
   output logic        core_rst,
   output logic        busy,
   output logic        done,
   output logic [31:0] CPU_Debug_DataCache_A2,
   output logic [31:0] CPU_Debug_DataCache_WD2,
   output logic [3:0]  CPU_Debug_DataCache_WE2,
   input  logic [31:0] CPU_Debug_DataCache_RD2,
   output logic [31:0] CPU_Debug_InstCache_A2,
   output logic [31:0] CPU_Debug_InstCache_WD2,
   output logic [3:0]  CPU_Debug_InstCache_WE2,
   input  logic [31:0] CPU_Debug_InstCache_RD2
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD      = 3'd1;
   localparam logic [2:0] S_RUN       = 3'd2;
   localparam logic [2:0] S_DUMP_ADDR = 3'd3;
   localparam logic [2:0] S_DUMP_WAIT = 3'd4;
   localparam logic [2:0] S_DUMP_OUT  = 3'd5;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_DUMP = 2'b01;
   localparam logic [1:0] OP_RUN  = 2'b10;

   function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] i);
      return {{(30-CNT_W){1'b0}}, i, 2'b00};
   endfunction

   logic [2:0]       state_q, state_d;
   logic             tgt_q, tgt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [31:0]      run_cnt_q, run_cnt_d;
   logic             fin_q, fin_d;
   logic             done_q, done_d;
   logic             core_rst_q, core_rst_d;
   logic             rd_valid_q, rd_valid_d;
   logic             rd_last_q, rd_last_d;
   logic [31:0]      rd_data_q, rd_data_d;
   logic [31:0]      dc_a2_q, dc_a2_d, dc_wd2_q, dc_wd2_d;
   logic [3:0]       dc_we2_q, dc_we2_d;
   logic [31:0]      ic_a2_q, ic_a2_d, ic_wd2_q, ic_wd2_d;
   logic [3:0]       ic_we2_q, ic_we2_d;

   // Port-independent view of the next port-2 drive; split per target below.
   logic [31:0]      a2_n, wd2_n;
   logic [3:0]       we2_n;
   logic [CNT_W-1:0] cmd_count, idx_inc;
   logic             is_last;
   logic [31:0]      rd2_sel;

   assign cmd_count = (cmd_arg == 32'd0 || cmd_arg > 32'(BRAMWORDS))
                      ? CNT_W'(BRAMWORDS) : cmd_arg[CNT_W-1:0];
   assign idx_inc   = idx_q + CNT_W'(1);
   assign is_last   = (idx_q == count_q - CNT_W'(1));
   assign rd2_sel   = tgt_q ? CPU_Debug_InstCache_RD2 : CPU_Debug_DataCache_RD2;

   // fin_q/done_q keep cmd_ready low until the cycle after done, so a command
   // can never be taken in the same cycle as the previous command's done.
   assign cmd_ready = (state_q == S_IDLE) && !fin_q && !done_q && !CPU_RST;
   assign wr_ready  = (state_q == S_LOAD);
   assign busy      = (state_q != S_IDLE);

   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      count_d    = count_q;
      idx_d      = idx_q;
      run_cnt_d  = run_cnt_q;
      fin_d      = 1'b0;
      done_d     = fin_q;   // LOAD completion is reported one cycle late
      core_rst_d = 1'b1;
      rd_valid_d = rd_valid_q;
      rd_last_d  = rd_last_q;
      rd_data_d  = rd_data_q;
      a2_n       = tgt_q ? ic_a2_q  : dc_a2_q;
      wd2_n      = tgt_q ? ic_wd2_q : dc_wd2_q;
      we2_n      = 4'h0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               tgt_d   = cmd_target;
               count_d = cmd_count;
               idx_d   = '0;
               a2_n    = '0;
               wd2_n   = '0;
               case (cmd_op)
                  OP_LOAD: state_d = S_LOAD;
                  OP_DUMP: state_d = S_DUMP_ADDR;
                  OP_RUN: begin
                     if (cmd_arg == 32'd0) begin
                        done_d = 1'b1;
                     end else begin
                        state_d    = S_RUN;
                        run_cnt_d  = cmd_arg;
                        core_rst_d = 1'b0;
                     end
                  end
                  default: done_d = 1'b1;
               endcase
            end
         end
         S_LOAD: begin
            if (wr_valid) begin
               a2_n  = word_addr(idx_q);
               wd2_n = wr_data;
               we2_n = 4'hF;
               if (is_last) begin
                  state_d = S_IDLE;
                  fin_d   = 1'b1;
               end else begin
                  idx_d = idx_inc;
               end
            end
         end
         S_RUN: begin
            run_cnt_d = run_cnt_q - 32'd1;
            if (run_cnt_q == 32'd1) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               core_rst_d = 1'b0;
            end
         end
         S_DUMP_ADDR: state_d = S_DUMP_WAIT;
         S_DUMP_WAIT: begin
            // Read data for the address driven last cycle is on RD2 now.
            rd_data_d  = rd2_sel;
            rd_last_d  = is_last;
            rd_valid_d = 1'b1;
            state_d    = S_DUMP_OUT;
         end
         S_DUMP_OUT: begin
            if (rd_ready) begin
               rd_valid_d = 1'b0;
               rd_last_d  = 1'b0;
               if (is_last) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_inc;
                  a2_n    = word_addr(idx_inc);
                  state_d = S_DUMP_ADDR;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Only the selected cache sees traffic; the other port is held at zero.
      dc_a2_d  = tgt_d ? 32'd0 : a2_n;
      dc_wd2_d = tgt_d ? 32'd0 : wd2_n;
      dc_we2_d = tgt_d ? 4'h0  : we2_n;
      ic_a2_d  = tgt_d ? a2_n  : 32'd0;
      ic_wd2_d = tgt_d ? wd2_n : 32'd0;
      ic_we2_d = tgt_d ? we2_n : 4'h0;
   end

   always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
      if (CPU_RST) begin
         state_q    <= S_IDLE;
         tgt_q      <= 1'b0;
         count_q    <= '0;
         idx_q      <= '0;
         run_cnt_q  <= '0;
         fin_q      <= 1'b0;
         done_q     <= 1'b0;
         core_rst_q <= 1'b1;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
         dc_a2_q    <= '0;
         dc_wd2_q   <= '0;
         dc_we2_q   <= '0;
         ic_a2_q    <= '0;
         ic_wd2_q   <= '0;
         ic_we2_q   <= '0;
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         run_cnt_q  <= run_cnt_d;
         fin_q      <= fin_d;
         done_q     <= done_d;
         core_rst_q <= core_rst_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         rd_data_q  <= rd_data_d;
         dc_a2_q    <= dc_a2_d;
         dc_wd2_q   <= dc_wd2_d;
         dc_we2_q   <= dc_we2_d;
         ic_a2_q    <= ic_a2_d;
         ic_wd2_q   <= ic_wd2_d;
         ic_we2_q   <= ic_we2_d;
      end
   end

   assign core_rst                = core_rst_q;
   assign done                    = done_q;
   assign rd_valid                = rd_valid_q;
   assign rd_last                 = rd_last_q;
   assign rd_data                 = rd_data_q;
   assign CPU_Debug_DataCache_A2  = dc_a2_q;
   assign CPU_Debug_DataCache_WD2 = dc_wd2_q;
   assign CPU_Debug_DataCache_WE2 = dc_we2_q;
   assign CPU_Debug_InstCache_A2  = ic_a2_q;
   assign CPU_Debug_InstCache_WD2 = ic_wd2_q;
   assign CPU_Debug_InstCache_WE2 = ic_we2_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_bram_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_bram_sequencer
// Purpose  : Self-checking bench for debug_bram_sequencer. Two 1-cycle-latency
//            BRAM models sit on port 2; a reference memory image plus cycle
//            arithmetic predicts strobes, dump data, core_rst and done timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_debug_bram_sequencer;

   localparam int BRAMWORDS = 4096;
   localparam int CNT_W     = 13;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_target;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_arg;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid, rd_ready, rd_last;
   logic [31:0] rd_data;
   logic        core_rst, busy, done;
   logic [31:0] dc_a2, dc_wd2, dc_rd2, ic_a2, ic_wd2, ic_rd2;
   logic [3:0]  dc_we2, ic_we2;

   debug_bram_sequencer #(.BRAMWORDS(BRAMWORDS), .CNT_W(CNT_W)) dut (
      .CPU_CLK(clk), .CPU_RST(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_target(cmd_target), .cmd_arg(cmd_arg),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .core_rst(core_rst), .busy(busy), .done(done),
      .CPU_Debug_DataCache_A2(dc_a2), .CPU_Debug_DataCache_WD2(dc_wd2),
      .CPU_Debug_DataCache_WE2(dc_we2), .CPU_Debug_DataCache_RD2(dc_rd2),
      .CPU_Debug_InstCache_A2(ic_a2), .CPU_Debug_InstCache_WD2(ic_wd2),
      .CPU_Debug_InstCache_WE2(ic_we2), .CPU_Debug_InstCache_RD2(ic_rd2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM models: synchronous read, one cycle latency, full-word writes.
   logic [31:0] mem_dc [0:BRAMWORDS-1];
   logic [31:0] mem_ic [0:BRAMWORDS-1];
   always @(posedge clk) begin
      if (dc_we2 == 4'hF) mem_dc[dc_a2[13:2]] <= dc_wd2;
      if (ic_we2 == 4'hF) mem_ic[ic_a2[13:2]] <= ic_wd2;
      dc_rd2 <= mem_dc[dc_a2[13:2]];
      ic_rd2 <= mem_ic[ic_a2[13:2]];
   end

   // Reference image of both caches: [0] DataCache, [1] InstCache.
   logic [31:0] ref_mem [0:1][0:BRAMWORDS-1];

   typedef struct packed {
      logic        port;
      logic [31:0] a;
      logic [31:0] d;
      int          c;
   } wr_t;

   wr_t  wlog[$];
   int   other_dirty = 0, low_cnt = 0, done_cnt = 0;
   logic cur_tgt = 1'b0;

   always @(negedge clk) begin
      if (dc_we2 != 4'h0) wlog.push_back('{1'b0, dc_a2, dc_wd2, cyc});
      if (ic_we2 != 4'h0) wlog.push_back('{1'b1, ic_a2, ic_wd2, cyc});
      if (busy && cur_tgt  && (dc_a2 != 0 || dc_wd2 != 0 || dc_we2 != 0)) other_dirty++;
      if (busy && !cur_tgt && (ic_a2 != 0 || ic_wd2 != 0 || ic_we2 != 0)) other_dirty++;
      if (!core_rst) low_cnt++;
      if (done) done_cnt++;
   end

   int n_vec = 0, n_miss = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nwords(input logic [31:0] a);
      return (a == 0 || a > BRAMWORDS) ? BRAMWORDS : int'(a);
   endfunction

   task automatic send_cmd(input logic [1:0] op, input logic tgt, input logic [31:0] arg,
                           output int hs);
      int budget = 20;
      cmd_valid = 1'b1; cmd_op = op; cmd_target = tgt; cmd_arg = arg;
      while (!cmd_ready && budget > 0) begin tick(); budget--; end
      check("cmd_accept", {31'b0, cmd_ready}, 32'd1);
      hs = cyc;
      tick();
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_target = 1'($urandom); cmd_arg = $urandom;
   endtask

   task automatic wait_done(input int exp_cyc, input string tag);
      int budget = 20000;
      while (!done && budget > 0) begin tick(); budget--; end
      check({tag, " done_seen"}, {31'b0, done}, 32'd1);
      check({tag, " done_cycle"}, cyc, exp_cyc);
      check({tag, " core_rst_at_done"}, {31'b0, core_rst}, 32'd1);
      check({tag, " ready_at_done"}, {31'b0, cmd_ready}, 32'd0);
      tick();
      check({tag, " done_pulse_end"}, {31'b0, done}, 32'd0);
      check({tag, " ready_after_done"}, {31'b0, cmd_ready}, 32'd1);
   endtask

   task automatic do_load(input logic tgt, input logic [31:0] arg, input bit dense,
                          input string tag);
      int n = nwords(arg);
      int hs, k = 0, budget, bad = 0, not_rdy = 0;
      int base = wlog.size(), low0 = low_cnt, dirty0 = other_dirty;
      int acc[$];
      logic [31:0] words[$];
      wr_t e;
      cur_tgt = tgt;
      send_cmd(2'b00, tgt, arg, hs);
      budget = 8 * n + 20;
      while (k < n && budget > 0) begin
         wr_valid = dense ? 1'b1 : 1'($urandom_range(0, 1));
         wr_data  = $urandom;
         rd_ready = 1'($urandom);
         if (wr_valid) begin
            if (!wr_ready) not_rdy++;
            words.push_back(wr_data);
            acc.push_back(cyc);
            ref_mem[tgt][k] = wr_data;
            k++;
         end
         tick(); budget--;
      end
      wr_valid = 1'b0;
      check({tag, " words_sent"}, k, n);
      check({tag, " wr_ready_low"}, not_rdy, 0);
      wait_done((k > 0) ? acc[k-1] + 2 : 0, tag);
      check({tag, " n_writes"}, wlog.size() - base, n);
      for (int i = 0; i < n && base + i < wlog.size(); i++) begin
         e = wlog[base + i];
         if (n <= 16) begin
            check($sformatf("%s w%0d addr", tag, i), e.a, 32'(4 * i));
            check($sformatf("%s w%0d data", tag, i), e.d, words[i]);
            check($sformatf("%s w%0d cycle", tag, i), e.c, acc[i] + 1);
            check($sformatf("%s w%0d port", tag, i), {31'b0, e.port}, {31'b0, tgt});
         end else if (e.port !== tgt || e.a !== 32'(4 * i) || e.d !== words[i] ||
                      e.c !== acc[i] + 1) begin
            bad++;
         end
      end
      if (n > 16) begin
         check({tag, " bad_writes"}, bad, 0);
         if (wlog.size() > 0) check({tag, " last_addr"}, wlog[wlog.size()-1].a, 32'(4 * (n - 1)));
      end
      check({tag, " other_port_idle"}, other_dirty - dirty0, 0);
      check({tag, " core_rst_low"}, low_cnt - low0, 0);
   endtask

   // mode 0: rd_ready tied high, 1: toggles 1/0, 2: random
   task automatic do_dump(input logic tgt, input logic [31:0] arg, input int mode,
                          input string tag);
      int n = nwords(arg);
      int hs, k = 0, budget, first = -1, prev = -1;
      int base = wlog.size(), low0 = low_cnt, dirty0 = other_dirty;
      cur_tgt = tgt;
      send_cmd(2'b01, tgt, arg, hs);
      budget = 12 * n + 20;
      while (k < n && budget > 0) begin
         rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~cyc[0] : 1'($urandom);
         wr_valid = 1'($urandom);
         wr_data  = $urandom;
         if (rd_valid) begin
            if (first < 0) first = cyc;
            check($sformatf("%s d%0d data", tag, k), rd_data, ref_mem[tgt][k]);
            check($sformatf("%s d%0d last", tag, k), {31'b0, rd_last}, {31'b0, k == n - 1});
            if (rd_ready) begin
               if (mode == 0 && k > 0) check($sformatf("%s d%0d spacing", tag, k), cyc - prev, 3);
               prev = cyc;
               k++;
            end
         end
         tick(); budget--;
      end
      rd_ready = 1'b0; wr_valid = 1'b0;
      check({tag, " words_read"}, k, n);
      check({tag, " first_valid"}, first, hs + 3);
      wait_done(prev + 1, tag);
      check({tag, " no_writes"}, wlog.size() - base, 0);
      check({tag, " other_port_idle"}, other_dirty - dirty0, 0);
      check({tag, " core_rst_low"}, low_cnt - low0, 0);
   endtask

   task automatic do_run(input logic [1:0] op, input logic [31:0] arg, input string tag);
      int hs, budget, rdy_hi = 0, first_low = -1;
      int base = wlog.size(), low0 = low_cnt;
      int exp_low = (op == 2'b10) ? int'(arg) : 0;
      send_cmd(op, 1'($urandom), arg, hs);
      budget = exp_low + 10;
      while (!done && budget > 0) begin
         if (cmd_ready) rdy_hi++;
         if (!core_rst && first_low < 0) first_low = cyc;
         wr_valid = 1'($urandom); rd_ready = 1'($urandom);
         tick(); budget--;
      end
      wr_valid = 1'b0; rd_ready = 1'b0;
      check({tag, " core_rst_low_cycles"}, low_cnt - low0, exp_low);
      if (exp_low > 0) check({tag, " core_rst_fall"}, first_low, hs + 1);
      check({tag, " ready_while_busy"}, rdy_hi, 0);
      wait_done(hs + 1 + exp_low, tag);
      check({tag, " no_writes"}, wlog.size() - base, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int hs, base, d0, op, a;
      logic [31:0] w [3];
      for (int i = 0; i < BRAMWORDS; i++) begin
         mem_dc[i] <= '0;
         mem_ic[i] <= '0;
         ref_mem[0][i] = '0;
         ref_mem[1][i] = '0;
      end
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_target = 1'b0; cmd_arg = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      tick(); tick();
      check("rst cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("rst core_rst", {31'b0, core_rst}, 32'd1);
      check("rst busy", {31'b0, busy}, 32'd0);
      check("rst done", {31'b0, done}, 32'd0);
      check("rst wr_ready", {31'b0, wr_ready}, 32'd0);
      check("rst rd_valid", {31'b0, rd_valid}, 32'd0);
      check("rst rd_last", {31'b0, rd_last}, 32'd0);
      check("rst rd_data", rd_data, 32'd0);
      check("rst dc port", dc_a2 | dc_wd2 | {28'b0, dc_we2}, 32'd0);
      check("rst ic port", ic_a2 | ic_wd2 | {28'b0, ic_we2}, 32'd0);
      rst = 1'b0;
      #1;
      check("rel cmd_ready", {31'b0, cmd_ready}, 32'd1);
      tick();

      do_load(1'b0, 32'd4, 1'b1, "load_dc4");
      do_load(1'b1, 32'd3, 1'b0, "load_ic3");
      do_dump(1'b1, 32'd3, 1, "dump_ic3");
      do_run(2'b10, 32'd100, "run100");
      do_load(1'b0, 32'd0, 1'b1, "load_dc_arg0");
      do_load(1'b1, 32'd5000, 1'b1, "load_ic_arg5000");
      do_dump(1'b0, 32'd5, 0, "dump_dc5");

      // Abort a 4-word LOAD after its 2nd word has been written.
      cur_tgt = 1'b0;
      base = wlog.size(); d0 = done_cnt;
      send_cmd(2'b00, 1'b0, 32'd4, hs);
      for (int j = 0; j < 3; j++) begin
         w[j] = $urandom;
         wr_valid = 1'b1; wr_data = w[j];
         tick();
      end
      rst = 1'b1; wr_valid = 1'b0;
      #1;
      check("abort dc_we2", {28'b0, dc_we2}, 32'd0);
      check("abort core_rst", {31'b0, core_rst}, 32'd1);
      check("abort busy", {31'b0, busy}, 32'd0);
      check("abort cmd_ready", {31'b0, cmd_ready}, 32'd0);
      ref_mem[0][0] = w[0];
      ref_mem[0][1] = w[1];
      tick(); tick();
      rst = 1'b0;
      #1;
      for (int j = 0; j < 3; j++) tick();
      check("abort no_done", done_cnt - d0, 0);
      check("abort writes", wlog.size() - base, 2);
      do_dump(1'b0, 32'd2, 2, "dump_after_abort");
      do_dump(1'b0, 32'd3, 1, "dump3_after_abort");

      do_run(2'b10, 32'd0, "run0");
      do_run(2'b11, 32'd77, "reserved");

      for (int t = 0; t < 25; t++) begin
         for (int j = $urandom_range(0, 3); j > 0; j--) begin
            wr_valid = 1'($urandom); rd_ready = 1'($urandom);
            tick();
         end
         wr_valid = 1'b0; rd_ready = 1'b0;
         op = $urandom_range(0, 3);
         a  = $urandom_range(1, 12);
         case (op)
            0: do_load(1'($urandom), 32'(a), 1'($urandom), $sformatf("rnd%0d_load", t));
            1: do_dump(1'($urandom), 32'(a), $urandom_range(0, 2), $sformatf("rnd%0d_dump", t));
            2: do_run(2'b10, 32'($urandom_range(0, 30)), $sformatf("rnd%0d_run", t));
            default: do_run(2'b11, $urandom, $sformatf("rnd%0d_rsvd", t));
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
